// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared resource to NUM_REQ requesters, with a bounded hold time
// that applies only while other requesters are waiting. Optional owner lock via `define ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no owner; any request is granted at the next edge
// OWNED | grant_q holds the one-hot owner; release checked every edge
module rr_resource_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               preempt
);

  localparam int             HCW      = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               busy_q,    busy_d;
  logic               preempt_q, preempt_d;
  logic [HCW-1:0]     hold_q,    hold_d;
  logic [IDW-1:0]     rr_ptr_q,  rr_ptr_d;

  logic               owner_req;
  logic               others_waiting;
  logic               lock_hold;
  logic               vol_release;
  logic               timeout;
  logic [IDW-1:0]     ptr_inc;
  logic [IDW-1:0]     search_ptr;
  logic [NUM_REQ-1:0] search_req;
  logic [IDW:0]       search_res;
  logic               win_found;
  logic [IDW-1:0]     win_id;

  // First set bit at or above ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IDW:0] find_winner(input logic [NUM_REQ-1:0] r,
                                               input logic [IDW-1:0]     ptr);
    logic           found;
    logic [IDW-1:0] win;
    int             idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    return {found, win};
  endfunction

  assign owner_req      = |(req & grant_q);
  assign others_waiting = |(req & ~grant_q);

`ifdef ARB_LOCK_EN
  assign lock_hold = lock & owner_req;
`else
  assign lock_hold = 1'b0;
`endif

  assign vol_release = ~owner_req;
  assign timeout     = (hold_q == HOLD_SAT) && others_waiting && !lock_hold;
  assign ptr_inc     = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

  // One search serves both cases: fresh grant from IDLE, or handoff excluding the releasing owner.
  assign search_ptr = (state_q == OWNED) ? ptr_inc : rr_ptr_q;
  assign search_req = (state_q == OWNED) ? (req & ~grant_q) : req;
  assign search_res = find_winner(search_req, search_ptr);
  assign win_found  = search_res[IDW];
  assign win_id     = search_res[IDW-1:0];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;
    hold_d     = hold_q;
    rr_ptr_d   = rr_ptr_q;

    if (state_q == IDLE) begin
      if (win_found) begin
        state_d    = OWNED;
        grant_d    = NUM_REQ'(1) << win_id;
        grant_id_d = win_id;
        busy_d     = 1'b1;
        hold_d     = '0;
      end
    end else begin
      if (vol_release || timeout) begin
        rr_ptr_d = ptr_inc;
        if (win_found) begin
          grant_d    = NUM_REQ'(1) << win_id;
          grant_id_d = win_id;
          hold_d     = '0;
          preempt_d  = ~vol_release;
        end else begin
          // grant_id deliberately keeps the last owner
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end else if (hold_q != HOLD_SAT) begin
        hold_d = hold_q + HCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
      hold_q     <= hold_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

  a_onehot : assert property (@(posedge clk) disable iff (!reset_L) $onehot0(grant_q));
  a_busy   : assert property (@(posedge clk) disable iff (!reset_L) busy_q == (|grant_q));
  a_owner  : assert property (@(posedge clk) disable iff (!reset_L) busy_q |-> grant_q[grant_id_q]);

endmodule
